// File: rtl/ssd1306_spi_tx.sv
// SPI transmitter for an SSD1306-class OLED controller.
// Queues {dc, data} entries in a small FIFO and shifts each byte out MSB-first
// in SPI mode 0. Chip select stays low across back-to-back bytes.
module ssd1306_spi_tx #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CS_IDLE    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_dc,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          overflow,
    output logic                          ss,
    output logic                          scl,
    output logic                          mosi,
    output logic                          dc
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDeselect
    } state_e;

    // FIFO storage and bookkeeping
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          push;
    logic          pop;
    logic          empty;
    logic [8:0]    head;

    // Transmit FSM state
    state_e        state_q, state_d;
    logic [7:0]    div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    cs_q, cs_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          scl_q, scl_d;
    logic          ss_q, ss_d;
    logic          mosi_q, mosi_d;
    logic          dc_q, dc_d;
    logic          tick;

    // A write while full is dropped even when a pop frees a slot in the same cycle.
    assign full  = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = wr_en && !full;
    assign head  = mem[rd_ptr_q];
    assign tick  = (div_q == 8'(CLK_DIV - 1));

    assign level    = count_q;
    assign overflow = ovf_q;
    assign busy     = !empty || (state_q != StIdle);
    assign ss       = ss_q;
    assign scl      = scl_q;
    assign mosi     = mosi_q;
    assign dc       = dc_q;

    // FIFO storage write port; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {wr_dc, wr_data};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
            if (wr_en && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // FSM and serial output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            cs_q    <= '0;
            shreg_q <= '0;
            scl_q   <= 1'b0;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
            dc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            cs_q    <= cs_d;
            shreg_q <= shreg_d;
            scl_q   <= scl_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            dc_q    <= dc_d;
        end
    end

    // Next-state logic: half-period divider, byte sequencing and pin updates
    always_comb begin
        state_d = state_q;
        div_d   = tick ? 8'd0 : div_q + 8'd1;
        bit_d   = bit_q;
        cs_d    = cs_q;
        shreg_d = shreg_q;
        scl_d   = scl_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
        dc_d    = dc_q;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = head[7:0];
                    mosi_d  = head[7];
                    dc_d    = head[8];
                    ss_d    = 1'b0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (tick) begin
                    scl_d   = 1'b1;
                    bit_d   = 3'd7;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (tick) begin
                    if (!scl_q) begin
                        scl_d = 1'b1;
                    end else begin
                        scl_d = 1'b0;
                        if (bit_q != 3'd0) begin
                            shreg_d = {shreg_q[6:0], 1'b0};
                            mosi_d  = shreg_q[6];
                            bit_d   = bit_q - 3'd1;
                        end else if (!empty) begin
                            // Chain the next byte with ss still low
                            pop     = 1'b1;
                            shreg_d = head[7:0];
                            mosi_d  = head[7];
                            dc_d    = head[8];
                            state_d = StSetup;
                        end else begin
                            state_d = StHold;
                        end
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    ss_d    = 1'b1;
                    cs_d    = 8'd0;
                    state_d = StDeselect;
                end
            end
            StDeselect: begin
                if (tick) begin
                    if (cs_q == 8'(CS_IDLE - 1)) begin
                        state_d = StIdle;
                    end else begin
                        cs_d = cs_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Every state entry restarts the half-period divider
        if (state_d != state_q) begin
            div_d = 8'd0;
        end
    end

endmodule

// File: doc/ssd1306_spi_tx.md
# ssd1306_spi_tx

Hardware SPI transmitter that drives an SSD1306-class OLED controller over its 4-wire serial interface: ss, scl, mosi and dc. Command and data bytes, each tagged with a DC bit, are queued through a FIFO write port and shifted out MSB-first in SPI mode 0. CS is held low across back-to-back bytes. The block sits on the transmit side of the OLED link: it lets the core, or a frame-buffer streamer, feed the OLED or the in-fabric ssd1306 raster model without bit-banging a port.

## Interface
- CLK_DIV, default 4: half-period of scl in clk cycles (1..255); scl = clk / (2*CLK_DIV).
- FIFO_DEPTH, default 16: entries, power of two, minimum 2; each entry is 9 bits {dc, data[7:0]}.
- CS_IDLE, default 2: half-periods ss stays high between bursts (minimum 1).
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  push {wr_dc, wr_data} when high and full is low.
- wr_data  input  8  byte to send.
- wr_dc  input  1  0 = command, 1 = display data.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  output  1  FIFO not empty or FSM not in IDLE.
- overflow  output  1  sticky; set when wr_en is high while full is high.
- ss  output  1  chip select, active low.
- scl  output  1  serial clock, idles low.
- mosi  output  1  serial data.
- dc  output  1  data/command select, valid for the whole byte.

## Operation
- Reset (rst low, asynchronous): ss=1, scl=0, mosi=0, dc=0, full=0, level=0, busy=0, overflow=0. FIFO is emptied and the FSM goes to IDLE.
- FIFO:
  - Synchronous; write and pop in the same cycle keep level unchanged.
  - A write while full is dropped, even if a pop happens in that same cycle, and sets overflow.
- Half-period tick: the divider counts 0..CLK_DIV-1 and ticks at CLK_DIV-1. The divider is cleared on every state entry.
- FSM states: IDLE, SETUP, SHIFT, HOLD, DESELECT.
- IDLE: when the FIFO is not empty, in one cycle:
  - pop the entry and load the shift register;
  - dc <= entry dc, mosi <= bit 7, ss <= 0;
  - go to SETUP.
- SETUP: on tick, scl <= 1 (rising edge; bit 7 sampled), bit counter = 7, go to SHIFT.
- SHIFT: each tick toggles scl.
  - Rising tick: scl <= 1.
  - Falling tick with counter > 0: scl <= 0, shift, mosi <= next bit, counter decrements.
  - Falling tick with counter = 0 (end of byte), in the same cycle:
    - FIFO not empty: pop, load, update dc and mosi, go to SETUP. ss stays low.
    - FIFO empty: go to HOLD.
- HOLD: ss stays low for one half-period, then ss <= 1 and go to DESELECT.
- DESELECT: ss high for CS_IDLE half-periods, then go to IDLE.
- dc and mosi change only while scl = 0. dc changes only at byte boundaries.
- mosi holds its last value outside transfers. dc holds its last value after ss rises.

## Timing
- Write-to-ss-low latency from IDLE: the write is registered at edge N, then popped and ss falls at edge N+1.
- First scl rising edge: CLK_DIV cycles after ss falls.
- One byte = 16 half-periods = 16*CLK_DIV clk cycles. Back-to-back bytes have no gap, so the byte pitch is exactly 16*CLK_DIV cycles.
- Last scl falling edge to ss high: CLK_DIV cycles (HOLD).
- ss high time: CS_IDLE*CLK_DIV cycles before the next transfer can start.
- busy falls in the cycle the FSM enters IDLE with the FIFO empty.
- full and level update one cycle after the write or pop edge; they are registered.

## Test plan
- Single command: CLK_DIV=2, write 0xAE with dc=0 from idle.
  - ss low one cycle after the write.
  - 8 scl rising edges sample 1,0,1,0,1,1,1,0 with dc=0 throughout.
  - ss high 2 cycles after the last fall; busy=0 after CS_IDLE*2 more cycles.
- Burst: write data bytes 0x55, 0xAA, 0xFF (dc=1) in consecutive cycles.
  - ss stays low continuously; 24 rising edges in order.
  - Byte pitch is 32 cycles; a single ss pulse covers the whole burst.
- DC switch: write 0x21 (dc=0) then 0x00 (dc=1).
  - dc toggles only during the second SETUP, while scl=0.
  - ss does not rise between the two bytes.
- Overflow: FIFO_DEPTH=16, write 18 entries in consecutive cycles from idle.
  - full=1 after the 17th write; the 18th is dropped; overflow=1.
  - Exactly 17 bytes appear on mosi, in order.
- Reset mid-byte: drive rst low during bit 3 of a byte with 4 entries still queued.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release: level=0 and no further scl edges.
- Minimum divider: CLK_DIV=1, send 0x81.
  - scl toggles every cycle, giving a clk/2 waveform.
  - Bits are sampled correctly; one byte takes 16 cycles.
